pkt_rx_seq: RTL and testbench

//  Sequences serial temperature-packet reception in the clk_2 domain. Shifts serial bits into bytes,

---
 rtl/pkt_rx_pkg.sv | 26 ++
 rtl/ser2par_byte.sv | 39 +++
 rtl/pkt_rx_seq.sv | 101 ++++++++++
 tb/tb_pkt_rx_seq.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_rx_pkg.sv
// Shared types and defaults for the serial temperature-packet receiver.
// Header codes, packet/FSM enums and a saturating counter helper.
package pkt_rx_pkg;

  localparam int         PAYLOAD_BYTES_DEF = 4;
  localparam logic [7:0] HDR_TEMP_DEF      = 8'hA5;
  localparam logic [7:0] HDR_CHECK_DEF     = 8'hC3;

  typedef enum logic [1:0] {
    PKT_NONE  = 2'd0,
    PKT_TEMP  = 2'd1,
    PKT_CHECK = 2'd2
  } pkt_type_t;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_TEMP,
    ST_CHECK,
    ST_DRAIN
  } rx_state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ser2par_byte.sv
// Serial-to-parallel byte assembler: MSB-first shift, 3-bit bit counter,
// one-cycle byte_assembled pulse with the byte held on wr_data.
module ser2par_byte (
  input  logic       clk_2,
  input  logic       reset_n,
  input  logic       serial_data,
  input  logic       data_ena,
  output logic [7:0] wr_data,
  output logic       byte_assembled
);

  logic [6:0] shift_q;
  logic [2:0] bit_cnt;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      shift_q        <= '0;
      bit_cnt        <= '0;
      wr_data        <= '0;
      byte_assembled <= 1'b0;
    end else begin
      byte_assembled <= 1'b0;
      if (data_ena) begin
        shift_q <= {shift_q[5:0], serial_data};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          wr_data        <= {shift_q, serial_data};
          byte_assembled <= 1'b1;
        end
      end else begin
        // A gap in data_ena abandons any partial byte
        bit_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pkt_rx_seq.sv
// Packet reception sequencer: header decode, payload counting, FIFO push
// of temperature payload and error flagging. Optional stats under PKT_RX_STATS_EN.
module pkt_rx_seq
  import pkt_rx_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = PAYLOAD_BYTES_DEF,
  parameter logic [7:0] HDR_TEMP      = HDR_TEMP_DEF,
  parameter logic [7:0] HDR_CHECK     = HDR_CHECK_DEF
) (
  input  logic        clk_2,
  input  logic        reset_n,
  input  logic        serial_data,
  input  logic        data_ena,
  input  logic        fifo_full,
  output logic        wr_fifo,
  output logic [7:0]  wr_data,
  output logic        byte_assembled,
  output logic [1:0]  pkt_type,
  output logic        pkt_done,
  output logic        pkt_err
`ifdef PKT_RX_STATS_EN
  ,
  output logic [15:0] pkt_cnt,
  output logic [15:0] drop_cnt
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(PAYLOAD_BYTES - 1);

  rx_state_t state;
  pkt_type_t pkt_type_q;
  logic [3:0] pay_cnt;

  ser2par_byte u_ser2par (
    .clk_2          (clk_2),
    .reset_n        (reset_n),
    .serial_data    (serial_data),
    .data_ena       (data_ena),
    .wr_data        (wr_data),
    .byte_assembled (byte_assembled)
  );

  // Same-cycle qualification so a full FIFO is never written
  assign wr_fifo  = byte_assembled && (state == ST_TEMP) && !fifo_full;
  assign pkt_type = pkt_type_q;

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_HUNT;
      pkt_type_q <= PKT_NONE;
      pay_cnt    <= '0;
      pkt_done   <= 1'b0;
      pkt_err    <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
      if (byte_assembled) begin
        case (state)
          ST_HUNT: begin
            pay_cnt <= '0;
            if (wr_data == HDR_TEMP) begin
              state      <= ST_TEMP;
              pkt_type_q <= PKT_TEMP;
            end else if (wr_data == HDR_CHECK) begin
              state      <= ST_CHECK;
              pkt_type_q <= PKT_CHECK;
            end else begin
              pkt_err <= 1'b1;
            end
          end
          default: begin
            // A drop moves to DRAIN; the later HUNT assignment wins on the last byte
            if (state == ST_TEMP && fifo_full) begin
              pkt_err <= 1'b1;
              state   <= ST_DRAIN;
            end
            if (pay_cnt == LAST_IDX) begin
              state    <= ST_HUNT;
              pkt_done <= 1'b1;
            end else begin
              pay_cnt <= pay_cnt + 4'd1;
            end
          end
        endcase
      end
    end
  end

`ifdef PKT_RX_STATS_EN
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (pkt_done) pkt_cnt  <= sat_inc(pkt_cnt);
      if (pkt_err)  drop_cnt <= sat_inc(drop_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pkt_rx_seq.sv
// Directed testbench for pkt_rx_seq: packet scenarios with hand-computed results.
module tb_pkt_rx_seq;

  logic        clk_2 = 1'b0;
  logic        reset_n = 1'b0;
  logic        serial_data = 1'b0;
  logic        data_ena = 1'b0;
  logic        fifo_full = 1'b0;
  logic        wr_fifo;
  logic [7:0]  wr_data;
  logic        byte_assembled;
  logic [1:0]  pkt_type;
  logic        pkt_done;
  logic        pkt_err;
`ifdef PKT_RX_STATS_EN
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pkt_rx_seq dut (
    .clk_2          (clk_2),
    .reset_n        (reset_n),
    .serial_data    (serial_data),
    .data_ena       (data_ena),
    .fifo_full      (fifo_full),
    .wr_fifo        (wr_fifo),
    .wr_data        (wr_data),
    .byte_assembled (byte_assembled),
    .pkt_type       (pkt_type),
    .pkt_done       (pkt_done),
    .pkt_err        (pkt_err)
`ifdef PKT_RX_STATS_EN
    ,
    .pkt_cnt        (pkt_cnt),
    .drop_cnt       (drop_cnt)
`endif
  );

  always #5 clk_2 = ~clk_2;

  // Event monitor, sampled mid-cycle
  int cycle = 0;
  int n_wr = 0, n_ba = 0, n_done = 0, n_err = 0;
  logic [7:0] wr_q[$];
  logic [7:0] ba_q[$];
  int         ba_cyc[$];

  always @(posedge clk_2) cycle <= cycle + 1;

  always @(negedge clk_2) begin
    if (wr_fifo === 1'b1) begin
      n_wr++;
      wr_q.push_back(wr_data);
    end
    if (byte_assembled === 1'b1) begin
      n_ba++;
      ba_q.push_back(wr_data);
      ba_cyc.push_back(cycle);
    end
    if (pkt_done === 1'b1) n_done++;
    if (pkt_err === 1'b1) n_err++;
  end

  task automatic drive_bit(input logic b, input logic full);
    @(posedge clk_2);
    #1;
    serial_data = b;
    data_ena    = 1'b1;
    fifo_full   = full;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic full = 1'b0);
    for (int i = 7; i >= 0; i--) drive_bit(b[i], full);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_2);
      #1;
      serial_data = 1'b0;
      data_ena    = 1'b0;
      fifo_full   = 1'b0;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    n_checks++;
    if ({wr_fifo, byte_assembled, pkt_done, pkt_err} !== 4'b0) begin
      n_fail++;
      $display("FAIL %s strobes: got %b expected 0000", tag, {wr_fifo, byte_assembled, pkt_done, pkt_err});
    end
    n_checks++;
    if (wr_data !== 8'h00) begin
      n_fail++;
      $display("FAIL %s wr_data: got %h expected 00", tag, wr_data);
    end
    n_checks++;
    if (pkt_type !== 2'd0) begin
      n_fail++;
      $display("FAIL %s pkt_type: got %0d expected 0", tag, pkt_type);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk_2);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    idle(2);
  endtask

  // Shared result check for a packet: deltas of write/done/err counts and written data
  task automatic check_pkt(input string tag, input int wr0, input int d0, input int e0,
                           input int exp_wr, input int exp_done, input int exp_err,
                           input logic [7:0] exp_data[4], input logic [1:0] exp_type);
    n_checks++;
    if (n_wr - wr0 !== exp_wr) begin
      n_fail++;
      $display("FAIL %s write count: got %0d expected %0d", tag, n_wr - wr0, exp_wr);
    end
    for (int k = 0; k < exp_wr; k++) begin
      n_checks++;
      if (wr_q[wr0 + k] !== exp_data[k]) begin
        n_fail++;
        $display("FAIL %s write[%0d]: got %h expected %h", tag, k, wr_q[wr0 + k], exp_data[k]);
      end
    end
    n_checks++;
    if (n_done - d0 !== exp_done) begin
      n_fail++;
      $display("FAIL %s pkt_done count: got %0d expected %0d", tag, n_done - d0, exp_done);
    end
    n_checks++;
    if (n_err - e0 !== exp_err) begin
      n_fail++;
      $display("FAIL %s pkt_err count: got %0d expected %0d", tag, n_err - e0, exp_err);
    end
    n_checks++;
    if (pkt_type !== exp_type) begin
      n_fail++;
      $display("FAIL %s pkt_type: got %0d expected %0d", tag, pkt_type, exp_type);
    end
  endtask

  task automatic test_temp();
    logic [7:0] exp[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int wr0 = n_wr, d0 = n_done, e0 = n_err;
    send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    idle(4);
    check_pkt("temp", wr0, d0, e0, 4, 1, 0, exp, 2'd1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[5] = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    int b0 = n_ba;
    send_byte(8'hA5); send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    idle(4);
    n_checks++;
    if (n_ba - b0 !== 5) begin
      n_fail++;
      $display("FAIL b2b byte count: got %0d expected 5", n_ba - b0);
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (ba_q[b0 + k] !== exp[k]) begin
        n_fail++;
        $display("FAIL b2b byte[%0d]: got %h expected %h", k, ba_q[b0 + k], exp[k]);
      end
    end
    for (int k = 1; k < 5; k++) begin
      n_checks++;
      if (ba_cyc[b0 + k] - ba_cyc[b0 + k - 1] !== 8) begin
        n_fail++;
        $display("FAIL b2b spacing[%0d]: got %0d expected 8", k, ba_cyc[b0 + k] - ba_cyc[b0 + k - 1]);
      end
    end
  endtask

  task automatic test_check();
    logic [7:0] exp[4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    int wr0 = n_wr, d0 = n_done, e0 = n_err;
    send_byte(8'hC3); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    idle(4);
    check_pkt("check", wr0, d0, e0, 0, 1, 0, exp, 2'd2);
  endtask

  task automatic test_bad_header();
    logic [7:0] exp[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int wr0 = n_wr, d0 = n_done, e0 = n_err;
    send_byte(8'h5A);
    send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    idle(4);
    check_pkt("bad_header", wr0, d0, e0, 4, 1, 1, exp, 2'd1);
  endtask

  task automatic test_fifo_full();
    logic [7:0] exp[4] = '{8'h11, 8'h00, 8'h00, 8'h00};
    int wr0 = n_wr, d0 = n_done, e0 = n_err;
    // Full is high while the 2nd payload byte is presented (first bit of the 3rd)
    send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    idle(4);
    check_pkt("fifo_full", wr0, d0, e0, 1, 1, 1, exp, 2'd1);
  endtask

  task automatic test_stats();
`ifdef PKT_RX_STATS_EN
    n_checks++;
    if (pkt_cnt !== 16'd5) begin
      n_fail++;
      $display("FAIL stats pkt_cnt: got %0d expected 5", pkt_cnt);
    end
    n_checks++;
    if (drop_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL stats drop_cnt: got %0d expected 2", drop_cnt);
    end
`endif
  endtask

  task automatic test_partial();
    logic [7:0] exp[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int wr0 = n_wr, d0 = n_done, e0 = n_err, b0 = n_ba;
    send_byte(8'hA5); send_byte(8'h11);
    repeat (5) drive_bit(1'b1, 1'b0);
    idle(1);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    idle(4);
    n_checks++;
    if (n_ba - b0 !== 5) begin
      n_fail++;
      $display("FAIL partial byte count: got %0d expected 5", n_ba - b0);
    end
    check_pkt("partial", wr0, d0, e0, 4, 1, 0, exp, 2'd1);
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    int wr0, d0 = n_done, e0;
    send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22);
    repeat (3) drive_bit(1'b1, 1'b0);
    reset_n  = 1'b0;
    data_ena = 1'b0;
    repeat (2) @(negedge clk_2);
    check_outputs_zero("reset_mid");
    reset_n = 1'b1;
    idle(2);
    n_checks++;
    if (n_done - d0 !== 0) begin
      n_fail++;
      $display("FAIL reset_mid lost pkt_done: got %0d expected 0", n_done - d0);
    end
    wr0 = n_wr; d0 = n_done; e0 = n_err;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    idle(4);
    check_pkt("after_reset", wr0, d0, e0, 4, 1, 0, exp, 2'd1);
`ifdef PKT_RX_STATS_EN
    n_checks++;
    if ({pkt_cnt, drop_cnt} !== {16'd1, 16'd0}) begin
      n_fail++;
      $display("FAIL stats after reset: got %0d/%0d expected 1/0", pkt_cnt, drop_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_temp();
    test_back_to_back();
    test_check();
    test_bad_header();
    test_fifo_full();
    test_stats();
    test_partial();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
